// File: rtl/keypad_pkg.sv
// Shared constants and types for the microwave decimal keypad encoder.
package keypad_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned CODE_W   = 4;

    typedef logic [CODE_W-1:0]   key_code_t;
    typedef logic [NUM_KEYS-1:0] key_lines_t;

    localparam key_code_t KEY_CODE_RESET = 4'd0;

endpackage : keypad_pkg

// File: rtl/keypad_prio_enc_core.sv
// Combinational priority encoder: the highest pressed key line wins.
module keypad_prio_enc_core
    import keypad_pkg::*;
(
    input  logic [NUM_KEYS-1:0] d_in,
    output logic [CODE_W-1:0]   code,
    output logic                any
);

    always_comb begin
        // NOTE: default assigned before the loop so every path drives code and no latch is inferred.
        code = KEY_CODE_RESET;
        // Ascending scan: a later (higher) set bit overwrites a lower one.
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (d_in[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    assign any = |d_in;

endmodule : keypad_prio_enc_core

// File: rtl/keypad_priority_encoder.sv
// Keypad front end: encodes the highest key, qualifies it over STABLE_CYCLES
// edges and issues one Cin strobe per accepted press.
module keypad_priority_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] d_in,
    output logic [CODE_W-1:0]   d_out,
    output logic                Cin
);

    if (STABLE_CYCLES == 0 || STABLE_CYCLES > (2**CODE_W - 1)) begin : g_bad_stable_cycles
        $error("STABLE_CYCLES must be in 1..15");
    end

    localparam logic [CODE_W-1:0] STABLE_W = CODE_W'(STABLE_CYCLES);

    logic [CODE_W-1:0] code;
    logic              any;
    logic              valid;

    logic [CODE_W-1:0] cnt_q,   cnt_d;
    logic [CODE_W-1:0] last_q,  last_d;
    logic              armed_q, armed_d;
    logic [CODE_W-1:0] dout_q,  dout_d;
    logic              cin_q,   cin_d;

    keypad_prio_enc_core u_core (
        .d_in (d_in),
        .code (code),
        .any  (any)
    );

    assign valid = en & any;

    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        armed_d = armed_q;
        dout_d  = dout_q;
        cin_d   = 1'b0;

        if (!valid) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else begin
            if (code != last_q) begin
                last_d  = code;
                cnt_d   = CODE_W'(1);
                armed_d = 1'b1;
            end else if (cnt_q < STABLE_W) begin
                cnt_d = cnt_q + CODE_W'(1);
            end

            // Fire on the edge the count reaches the threshold; disarm so a held key strobes once.
            if (armed_d && (cnt_d == STABLE_W)) begin
                dout_d  = code;
                cin_d   = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            last_q  <= KEY_CODE_RESET;
            armed_q <= 1'b1;
            dout_q  <= KEY_CODE_RESET;
            cin_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the pre-edge values.
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
            cin_q   <= cin_d;
        end
    end

    assign d_out = dout_q;
    assign Cin   = cin_q;

endmodule : keypad_priority_encoder

// File: tb/tb_keypad_priority_encoder.sv
// Directed bench for keypad_priority_encoder with STABLE_CYCLES=3.
module tb_keypad_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] d_in;
    logic [3:0] d_out;
    logic       Cin;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    keypad_priority_encoder #(.STABLE_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d_in  (d_in),
        .d_out (d_out),
        .Cin   (Cin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 ns later and tally strobes.
    task automatic step();
        @(posedge clk);
        #1;
        if (Cin === 1'b1) pulses++;
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        d_in  = 10'h200;

        // Reset held with key 9 pressed: outputs stay at zero.
        for (int r = 0; r < 3; r++) begin
            step();
            check("rst_dout", d_out, 0);
            check("rst_cin", Cin, 0);
        end

        // Release; key 9 accepted on the third edge.
        rst_n = 1'b1;
        step();
        check("rel_e1_cin", Cin, 0);
        check("rel_e1_dout", d_out, 0);
        step();
        check("rel_e2_cin", Cin, 0);
        step();
        check("rel_e3_cin", Cin, 1);
        check("rel_e3_dout", d_out, 9);
        step();
        check("rel_e4_cin", Cin, 0);
        check("rel_e4_dout", d_out, 9);

        // Sweep each key: one strobe while enabled, value held while disabled.
        for (int i = 0; i < 10; i++) begin
            d_in   = 10'(1) << i;
            en     = 1'b1;
            pulses = 0;
            steps(10);
            check("sweep_pulses", pulses, 1);
            check("sweep_dout", d_out, i);
            en = 1'b0;
            steps(10);
            check("sweep_hold_pulses", pulses, 1);
            check("sweep_hold_dout", d_out, i);
        end

        // Priority: keys 0,2,5 -> 5.
        en   = 1'b1;
        d_in = 10'b0000100101;
        step();
        check("prio5_e1_cin", Cin, 0);
        step();
        check("prio5_e2_cin", Cin, 0);
        step();
        check("prio5_e3_cin", Cin, 1);
        check("prio5_e3_dout", d_out, 5);
        steps(2);
        check("prio5_hold_dout", d_out, 5);

        // Keys 0,9 -> 9, requalified from scratch.
        d_in = 10'b1000000001;
        step();
        check("prio9_e1_cin", Cin, 0);
        check("prio9_e1_dout", d_out, 5);
        step();
        check("prio9_e2_cin", Cin, 0);
        step();
        check("prio9_e3_cin", Cin, 1);
        check("prio9_e3_dout", d_out, 9);

        // Debounce: short press then release yields nothing.
        d_in = 10'h000;
        step();
        pulses = 0;
        d_in = 10'(1) << 3;
        steps(2);
        d_in = 10'h000;
        steps(3);
        check("bounce_pulses", pulses, 0);
        check("bounce_dout", d_out, 9);

        // Enable dropped mid-count: count discarded.
        d_in = 10'(1) << 3;
        en   = 1'b1;
        steps(2);
        en = 1'b0;
        steps(3);
        check("en_drop_pulses", pulses, 0);
        check("en_drop_dout", d_out, 9);

        // Long hold of key 7: single strobe.
        d_in   = 10'(1) << 7;
        en     = 1'b1;
        pulses = 0;
        steps(50);
        check("hold_pulses", pulses, 1);
        check("hold_dout", d_out, 7);

        // Release one cycle and press again: re-armed.
        d_in = 10'h000;
        step();
        d_in = 10'(1) << 7;
        steps(2);
        check("rearm_e2_cin", Cin, 0);
        step();
        check("rearm_e3_cin", Cin, 1);
        check("rearm_pulses", pulses, 2);
        check("rearm_dout", d_out, 7);

        // Async reset asserted while Cin is high.
        d_in = 10'h000;
        step();
        d_in = 10'(1) << 4;
        steps(3);
        check("pre_rst_cin", Cin, 1);
        check("pre_rst_dout", d_out, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cin", Cin, 0);
        check("async_rst_dout", d_out, 0);
        steps(2);
        check("async_hold_dout", d_out, 0);
        rst_n = 1'b1;
        d_in  = 10'h000;
        steps(2);
        check("post_rst_cin", Cin, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_keypad_priority_encoder
